// File: rtl/wb_arb_pkg.sv
// Shared definitions for the write-back arbiter: unit indices, counter width
// and the unit enumeration used to name the write-back winner.
package wb_arb_pkg;

  localparam int FSQRT    = 0;
  localparam int DIV      = 1;
  localparam int FDIV     = 2;
  localparam int FADD_SUB = 3;
  localparam int R4       = 4;
  localparam int FMUL     = 5;
  localparam int MUL      = 6;
  localparam int FP       = 7;
  localparam int ALU      = 8;

  localparam int WB_NUM_UNITS = 9;
  localparam int WB_STARVE_W  = 4;

  // DEFAULT_unit stands for "no grant this cycle"
  typedef enum logic [3:0] {
    UNIT_FSQRT    = 4'd0,
    UNIT_DIV      = 4'd1,
    UNIT_FDIV     = 4'd2,
    UNIT_FADD_SUB = 4'd3,
    UNIT_R4       = 4'd4,
    UNIT_FMUL     = 4'd5,
    UNIT_MUL      = 4'd6,
    UNIT_FP       = 4'd7,
    UNIT_ALU      = 4'd8,
    DEFAULT_unit  = 4'd15
  } wb_unit_t;

endpackage

// File: rtl/wb_arbiter_starve_cnt.sv
// Per-unit starvation counter: counts consecutive lost cycles of a requesting
// unit, saturating at the programmed limit.
module wb_starve_cnt
  import wb_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req,
  input  logic                   grant,
  input  logic [WB_STARVE_W-1:0] limit,
  output logic [WB_STARVE_W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (grant || !req) begin
      count <= '0;
    end else if (count < limit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the execute stage: fixed priority by unit index with
// optional starvation promotion (enabled by macro WB_ARB_STARVE_EN).
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int NUM_UNITS    = WB_NUM_UNITS,
  parameter  int STARVE_LIMIT = 4,
  parameter  int COLL_CNT_W   = 16,
  localparam int IDX_W        = $clog2(NUM_UNITS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_UNITS-1:0]  req,
  input  logic [NUM_UNITS-2:0]  start,
  input  logic                  rd_busy,
  output logic [NUM_UNITS-1:0]  grant,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  grant_vld,
  output logic [NUM_UNITS-1:0]  stall,
  output logic                  pipe_stall,
  output logic                  id_exe_clr,
  output logic [COLL_CNT_W-1:0] coll_cnt
);

  logic                 collision;
  logic [NUM_UNITS-1:0] eligible;
  logic [NUM_UNITS-1:0] promoted;
  logic [NUM_UNITS-1:0] pick;
  logic [NUM_UNITS-1:0] start_ext;

  assign collision = ($countones(req) > 1);
  // The ALU (top index) cannot write back while a RAW hazard is pending
  assign eligible  = req & ~{rd_busy, {(NUM_UNITS-1){1'b0}}};

`ifdef WB_ARB_STARVE_EN
  localparam logic [WB_STARVE_W-1:0] LIMIT = WB_STARVE_W'(STARVE_LIMIT);
  logic [WB_STARVE_W-1:0] starve_cnt [NUM_UNITS];

  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_starve
    wb_starve_cnt u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req[gi]),
      .grant   (grant[gi]),
      .limit   (LIMIT),
      .count   (starve_cnt[gi])
    );
    assign promoted[gi] = eligible[gi] & (starve_cnt[gi] == LIMIT);
  end
`else
  assign promoted = '0;
`endif

  assign pick = (|promoted) ? promoted : eligible;

  // Descending scan so the lowest set index is the last one written
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (pick[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
        grant_vld = 1'b1;
      end
    end
  end

  assign stall      = {NUM_UNITS{collision}} & req & ~grant;
  assign pipe_stall = collision;

  // The ALU has no start bit; pad so the lookup is always in range
  assign start_ext  = {1'b0, start};
  assign id_exe_clr = collision & grant_vld
                    & (grant_idx < IDX_W'(NUM_UNITS - 1))
                    & start_ext[grant_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coll_cnt <= '0;
    end else if (collision && !(&coll_cnt)) begin
      coll_cnt <= coll_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized held
// request patterns, checked against a rule-level reference model.
module tb_wb_arbiter;
  import wb_arb_pkg::*;

  localparam int N   = 9;
  localparam int LIM = 4;
  localparam int CW  = 4;
`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [N-2:0]  start;
  logic          rd_busy;
  logic [N-1:0]  grant;
  logic [3:0]    grant_idx;
  logic          grant_vld;
  logic [N-1:0]  stall;
  logic          pipe_stall;
  logic          id_exe_clr;
  logic [CW-1:0] coll_cnt;

  wb_arbiter #(.NUM_UNITS(N), .STARVE_LIMIT(LIM), .COLL_CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .start      (start),
    .rd_busy    (rd_busy),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld),
    .stall      (stall),
    .pipe_stall (pipe_stall),
    .id_exe_clr (id_exe_clr),
    .coll_cnt   (coll_cnt)
  );

  always #5 clk = ~clk;

  int n_vec    = 0;
  int n_miscmp = 0;
  int starve_m [N];
  int coll_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) starve_m[i] = 0;
    coll_m = 0;
  endfunction

  // Winner per the rules: promoted lowest index, else eligible lowest index
  function automatic int model_winner();
    int w = -1;
    for (int i = 0; i < N && w < 0; i++)
      if (STARVE_EN && req[i] && !(i == N-1 && rd_busy) && starve_m[i] == LIM) w = i;
    for (int i = 0; i < N && w < 0; i++)
      if (req[i] && !(i == N-1 && rd_busy)) w = i;
    return w;
  endfunction

  function automatic void model_update(input int w, input bit coll);
    for (int i = 0; i < N; i++) begin
      if (i == w || !req[i]) starve_m[i] = 0;
      else if (starve_m[i] < LIM) starve_m[i]++;
    end
    if (coll && coll_m < (1 << CW) - 1) coll_m++;
  endfunction

  task automatic check_outputs(input string tag, input int w, input bit coll);
    logic [N-1:0] eg;
    logic [N-1:0] es;
    bit           clr;
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    es  = coll ? (req & ~eg) : '0;
    clr = coll && (w >= 0) && (w < N-1) && start[w];
    check({tag, ".grant"},      grant,      eg);
    check({tag, ".grant_idx"},  grant_idx,  (w < 0) ? 0 : w);
    check({tag, ".grant_vld"},  grant_vld,  w >= 0);
    check({tag, ".stall"},      stall,      es);
    check({tag, ".pipe_stall"}, pipe_stall, coll);
    check({tag, ".id_exe_clr"}, id_exe_clr, clr);
    check({tag, ".coll_cnt"},   coll_cnt,   coll_m);
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-2:0] s, input logic b);
    req = r; start = s; rd_busy = b;
    #1;
  endtask

  task automatic step(input string tag);
    int w;
    bit coll;
    @(negedge clk);
    w    = model_winner();
    coll = ($countones(req) >= 2);
    check_outputs(tag, w, coll);
    $display("%s req=%b start=%b rd_busy=%b grant=%b idx=%0d stall=%b clr=%b coll_cnt=%0d",
             tag, req, start, rd_busy, grant, grant_idx, stall, id_exe_clr, coll_cnt);
    @(posedge clk);
    model_update(w, coll);
    #1;
  endtask

  task automatic flush();
    drive('0, '0, 1'b0);
    step("flush");
  endtask

  task automatic waw(input logic s5, input string tag);
    flush();
    for (int k = 0; k < LIM; k++) begin
      drive(9'b000100001, '0, 1'b0);
      step("waw_pre");
    end
    drive(9'b000100001, {s5, 5'b0}, 1'b0);
    check({tag, ".idx"}, grant_idx, STARVE_EN ? 5 : 0);
    check({tag, ".clr"}, id_exe_clr, STARVE_EN && s5);
    step(tag);
  endtask

  initial begin
    req = '0; start = '0; rd_busy = 1'b0; reset_n = 1'b0;
    model_reset();
    #2;
    check("rst.grant", grant, 0);
    check("rst.vld", grant_vld, 0);
    check("rst.coll_cnt", coll_cnt, 0);
    check_outputs("rst", model_winner(), 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    drive(9'b000010000, '0, 1'b0);
    check("single.idx", grant_idx, 4);
    check("single.stall", stall, 0);
    check("single.pipe", pipe_stall, 0);
    step("single");
    check("single.coll_cnt", coll_cnt, 0);

    drive(9'b100100110, '0, 1'b0);
    check("prio.idx", grant_idx, 1);
    check("prio.stall", stall, 9'b100100100);
    check("prio.pipe", pipe_stall, 1);
    step("prio");
    check("prio.coll_cnt", coll_cnt, 1);

    drive(9'b100000000, '0, 1'b1);
    check("busy.vld", grant_vld, 0);
    check("busy.stall", stall, 0);
    step("busy_alu");
    drive(9'b100001000, '0, 1'b1);
    check("busy2.idx", grant_idx, 3);
    check("busy2.stall8", stall[8], 1);
    step("busy_coll");

    flush();
    for (int k = 0; k < 6; k++) begin
      drive(9'b000100001, '0, 1'b0);
      check($sformatf("starve%0d.idx", k), grant_idx, (STARVE_EN && k == LIM) ? 5 : 0);
      step("starve");
    end

    waw(1'b1, "waw_start");
    waw(1'b0, "waw_nostart");

    flush();
    for (int k = 0; k < 3; k++) begin
      drive(9'b000100001, '0, 1'b0);
      step("pre_rst");
    end
    reset_n = 1'b0;
    #1;
    check("midrst.coll_cnt", coll_cnt, 0);
    model_reset();
    check_outputs("midrst", model_winner(), 1'b1);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < LIM + 1; k++) begin
      drive(9'b000100001, '0, 1'b0);
      check($sformatf("postrst%0d.idx", k), grant_idx, (STARVE_EN && k == LIM) ? 5 : 0);
      step("post_rst");
    end

    for (int c = 0; c < 400; ) begin
      logic [N-1:0] r;
      int           hold;
      r    = N'($urandom_range(0, 511));
      if ($urandom_range(0, 3) == 0) r = r & N'($urandom_range(0, 511));
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        drive(r, (N-1)'($urandom), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 60) == 0) begin
          reset_n = 1'b0;
          #1;
          model_reset();
          check_outputs("rnd_rst", model_winner(), $countones(req) >= 2);
          #1;
          reset_n = 1'b1;
        end
        step("rnd");
        c++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Parametrised write-back arbiter for the execute stage: selects one of NUM_UNITS functional-unit results per cycle to write the EXE/MEM register, stalls the losers and the front pipeline on collision, and flushes ID/EXE on a copy (WAW) hazard. Baseline policy is fixed priority by unit index. Per-unit starvation counters promote a unit that has lost STARVE_LIMIT consecutive cycles. A saturating collision counter is provided for performance monitoring.

## Interface
- NUM_UNITS, 9, number of requesters; index 0 = highest fixed priority, index NUM_UNITS-1 = single-cycle ALU
- STARVE_LIMIT, 4, consecutive lost cycles before a unit is promoted (1..15)
- COLL_CNT_W, 16, width of collision performance counter
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_UNITS  result-valid per unit
- start  in  NUM_UNITS-1  new instruction issued into pipelined/multi-cycle unit i this cycle
- rd_busy  in  1  RAW hazard pending; blocks ALU grant
- grant  out  NUM_UNITS  one-hot write-back grant, all-zero if none
- grant_idx  out  $clog2(NUM_UNITS)  index of granted unit, 0 when none
- grant_vld  out  1  any grant this cycle
- stall  out  NUM_UNITS  per-unit hold: req[i] & ~grant[i] & collision
- pipe_stall  out  1  front-pipeline stall
- id_exe_clr  out  1  ID/EXE clear request, ORed externally with id_exe_reg_clr
- coll_cnt  out  COLL_CNT_W  saturating count of collision cycles

## Operation
- Collision occurs when two or more bits of req are set.
- Eligible set is req, with bit NUM_UNITS-1 masked when rd_busy is set.
- Promoted set is the eligible units whose starve counter equals STARVE_LIMIT.
- Winner selection:
  - If the promoted set is non-empty, the lowest index in it wins.
  - Otherwise the lowest eligible index wins.
  - If nothing is eligible, there is no grant.
- stall[i] = collision & req[i] & ~grant[i]. A unit that loses only because of rd_busy (no collision) is not stalled.
- pipe_stall = collision.
- id_exe_clr = collision & grant_vld & (grant_idx < NUM_UNITS-1) & start[grant_idx].
- Starve counter i, 4-bit:
  - Clears when grant[i] is set or req[i] is clear.
  - Otherwise increments, saturating at STARVE_LIMIT.
- Only one unit can hold the winner slot. When several units are promoted, the lower index wins and the others stay saturated.
- coll_cnt increments on each collision cycle and saturates at all-ones.

## Timing
- grant, grant_idx, grant_vld, stall, pipe_stall and id_exe_clr are combinational from the inputs and registered counters, with zero-cycle latency.
- Counters and coll_cnt update on the rising edge of clk.
- A unit that loses on cycles t..t+STARVE_LIMIT-1 is promoted on cycle t+STARVE_LIMIT.
- Reset (asynchronous, any cycle including mid-collision):
  - All starve counters go to 0 and coll_cnt goes to 0.
  - Combinational outputs follow the inputs immediately.
  - With req=0, all outputs are 0.
- Simultaneous events:
  - If a unit's req drops in the same cycle it would be promoted, its counter clears and it is not granted.
  - If start and grant hit the same unit on a collision cycle, id_exe_clr is asserted that cycle only.
- Without a collision, rd_busy with only the ALU requesting gives grant_vld=0 and stall=0.

## Configuration
- Macro WB_ARB_STARVE_EN.
- Defined: starvation promotion is active as described above.
- Undefined:
  - The promoted set is forced empty, giving pure fixed-index priority.
  - Starve counters are not instantiated.
  - All other behaviour, including coll_cnt, is unchanged.

## Structure
- Package wb_arb_pkg holds:
  - Unit index localparams: FSQRT=0, DIV=1, FDIV=2, FADD_SUB=3, R4=4, FMUL=5, MUL=6, FP=7, ALU=8.
  - WB_NUM_UNITS=9.
  - The wb_unit_t enum, replacing priority_t, with DEFAULT_unit mapped to "no grant".
- One sub-module, wb_starve_cnt: a per-unit saturating 4-bit counter with inputs req, grant and limit. It is generated NUM_UNITS times under WB_ARB_STARVE_EN.

## Test plan
- Single requester: req=9'b000010000, no collision → grant_idx=4, stall=0, pipe_stall=0, coll_cnt unchanged.
- Fixed priority: req=9'b100100110 → grant_idx=1, stall=9'b100100100, pipe_stall=1, coll_cnt +1.
- Starvation: req bits 0 and 5 held for 6 cycles with STARVE_LIMIT=4 → unit 0 wins cycles 0-3 and unit 5 wins cycle 4; without WB_ARB_STARVE_EN, unit 0 wins all cycles.
- rd_busy: req=9'b100000000 with rd_busy=1 → grant_vld=0, stall=0; then req=9'b100001000 with rd_busy=1 → grant_idx=3, stall[8]=1.
- WAW: req=9'b000100001, start[5]=1, unit 5 promoted → grant_idx=5, id_exe_clr=1. Repeat with start[5]=0 → id_exe_clr=0.
- Reset mid-operation: counters at 3 with collisions ongoing, pulse reset_n low → counters=0 and coll_cnt=0 immediately, and arbitration restarts with pure fixed priority.
